// File: rtl/biss_rx_pkg.sv
// Shared types and constants for the BiSS-C frame receiver.
package biss_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      ACK,
      START,
      CDS,
      DATA,
      DONE
   } state_e;

   localparam int unsigned CRC_W = 6;
   localparam logic [CRC_W-1:0] CRC6_POLY = 6'h03;
   localparam int unsigned CFG_W = 8;
   localparam int unsigned POS_W_MIN = 8;

   // Out-of-range widths fall back to the widest supported field.
   function automatic logic [CFG_W-1:0] clamp_pos_width(input logic [CFG_W-1:0] cfg,
                                                        input int unsigned max_w);
      if (32'(cfg) < POS_W_MIN || 32'(cfg) > max_w) begin
         return CFG_W'(max_w);
      end
      return cfg;
   endfunction

endpackage

// File: rtl/biss_crc6_serial.sv
// Bit-serial CRC6 (x^6+x+1, init 0), MSB-first.
module biss_crc6_serial
   import biss_rx_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] crc_q, crc_d;
   logic             fb;

   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[CRC_W-1] ^ din;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC6_POLY : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/biss_rx_frame_v3.sv
// Passive BiSS-C receiver: sniffs MA/SLO, decodes runtime-width frames,
// checks CRC6 and reports position, status, frame count and frame period.
module biss_rx_frame_v3
   import biss_rx_pkg::*;
#(
   parameter int unsigned POS_W_MAX   = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SYNC_EDGES  = 2,
   parameter int unsigned BIT_TO      = 50,
   parameter int unsigned ACK_TO      = 2000,
   parameter int unsigned PERIOD_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 motion_en,
   input  logic [CFG_W-1:0]     cfg_pos_width,
   input  logic                 ma_in,
   input  logic                 slo_in,
   output logic                 ma_out,
   output logic                 slo_out,
   output logic                 frame_valid,
   output logic [POS_W_MAX-1:0] pos_out,
   output logic                 err_bit,
   output logic                 warn_bit,
   output logic                 crc_ok,
   output logic                 proto_err,
   output logic [15:0]          frame_cnt,
   output logic [PERIOD_W-1:0]  frame_period
);

   localparam int unsigned TO_MAX = (ACK_TO > BIT_TO) ? ACK_TO : BIT_TO;
   localparam int unsigned TMR_W  = $clog2(TO_MAX + 1);
   localparam int unsigned BIT_W  = $clog2(POS_W_MAX + 9);
   localparam int unsigned SCNT_W = (SYNC_EDGES < 2) ? 1 : $clog2(SYNC_EDGES + 1);

   logic                 sync_clr;
   logic [SYNC_STAGES-1:0] ma_sync_q, slo_sync_q;
   logic                 ma_prev_q;
   logic                 ma_s, slo_s, ma_fall, ma_edge;

   state_e               state_q, state_d;
   logic [SCNT_W-1:0]    scnt_q, scnt_d;
   logic [BIT_W-1:0]     n_q, n_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [POS_W_MAX-1:0] pos_sh_q, pos_sh_d;
   logic                 err_sh_q, err_sh_d, warn_sh_q, warn_sh_d;
   logic [CRC_W-1:0]     crc_rx_q, crc_rx_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [PERIOD_W-1:0]  period_q, period_d;

   logic                 frame_valid_q, frame_valid_d;
   logic [POS_W_MAX-1:0] pos_out_q, pos_out_d;
   logic                 err_bit_q, err_bit_d, warn_bit_q, warn_bit_d;
   logic                 crc_ok_q, crc_ok_d, proto_err_q, proto_err_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;
   logic [PERIOD_W-1:0]  frame_period_q, frame_period_d;

   logic                 crc_clr, crc_en;
   logic [CRC_W-1:0]     crc_calc;

   assign sync_clr = rst | ~motion_en;
   assign ma_s     = ma_sync_q[SYNC_STAGES-1];
   assign slo_s    = slo_sync_q[SYNC_STAGES-1];
   assign ma_fall  = ma_prev_q & ~ma_s;
   assign ma_edge  = ma_prev_q ^ ma_s;

   biss_crc6_serial u_crc (
      .clk (clk),
      .rst (sync_clr),
      .clr (crc_clr),
      .en  (crc_en),
      .din (slo_s),
      .crc (crc_calc)
   );

   // Frame FSM: timeouts take priority over edge handling in every state.
   always_comb begin
      state_d        = state_q;
      scnt_d         = scnt_q;
      n_d            = n_q;
      bit_d          = bit_q;
      pos_sh_d       = pos_sh_q;
      err_sh_d       = err_sh_q;
      warn_sh_d      = warn_sh_q;
      crc_rx_d       = crc_rx_q;
      pos_out_d      = pos_out_q;
      err_bit_d      = err_bit_q;
      warn_bit_d     = warn_bit_q;
      crc_ok_d       = crc_ok_q;
      frame_cnt_d    = frame_cnt_q;
      frame_period_d = frame_period_q;
      frame_valid_d  = 1'b0;
      proto_err_d    = 1'b0;
      crc_clr        = 1'b0;
      crc_en         = 1'b0;
      period_d       = (period_q == '1) ? period_q : period_q + PERIOD_W'(1);
      if (ma_edge || state_q == IDLE) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TMR_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (ma_fall && slo_s) begin
               n_d      = BIT_W'(clamp_pos_width(cfg_pos_width, POS_W_MAX));
               scnt_d   = SCNT_W'(1);
               bit_d    = '0;
               pos_sh_d = '0;
               crc_clr  = 1'b1;
               state_d  = (SYNC_EDGES <= 1) ? ACK : SYNC;
            end
         end
         SYNC: begin
            if (timer_q == TMR_W'(BIT_TO)) begin
               proto_err_d = 1'b1;
               state_d     = IDLE;
            end else if (ma_fall) begin
               if (slo_s) begin
                  scnt_d = scnt_q + SCNT_W'(1);
                  if (scnt_q + SCNT_W'(1) >= SCNT_W'(SYNC_EDGES)) begin
                     state_d = ACK;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end
         ACK: begin
            if (timer_q == TMR_W'(BIT_TO)) begin
               proto_err_d = 1'b1;
               state_d     = IDLE;
            end else if (ma_fall && !slo_s) begin
               state_d = START;
            end
         end
         START: begin
            if (timer_q == TMR_W'(ACK_TO)) begin
               proto_err_d = 1'b1;
               state_d     = IDLE;
            end else if (ma_fall && slo_s) begin
               // Counter holds cycles-1 since the previous start bit.
               frame_period_d = (period_q == '1) ? period_q : period_q + PERIOD_W'(1);
               period_d       = '0;
               state_d        = CDS;
            end
         end
         CDS: begin
            if (timer_q == TMR_W'(BIT_TO)) begin
               proto_err_d = 1'b1;
               state_d     = IDLE;
            end else if (ma_fall) begin
               if (slo_s) begin
                  proto_err_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (timer_q == TMR_W'(BIT_TO)) begin
               proto_err_d = 1'b1;
               state_d     = IDLE;
            end else if (ma_fall) begin
               bit_d  = bit_q + BIT_W'(1);
               crc_en = (bit_q < n_q + BIT_W'(2));
               if (bit_q < n_q) begin
                  pos_sh_d = {pos_sh_q[POS_W_MAX-2:0], slo_s};
               end else if (bit_q == n_q) begin
                  err_sh_d = slo_s;
               end else if (bit_q == n_q + BIT_W'(1)) begin
                  warn_sh_d = slo_s;
               end else begin
                  crc_rx_d = {crc_rx_q[CRC_W-2:0], slo_s};
               end
               if (bit_q == n_q + BIT_W'(7)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            pos_out_d     = pos_sh_q;
            err_bit_d     = err_sh_q;
            warn_bit_d    = warn_sh_q;
            crc_ok_d      = (crc_calc == ~crc_rx_q);
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_clr) begin
         ma_sync_q      <= '0;
         slo_sync_q     <= '0;
         ma_prev_q      <= 1'b0;
         state_q        <= IDLE;
         scnt_q         <= '0;
         n_q            <= '0;
         bit_q          <= '0;
         pos_sh_q       <= '0;
         err_sh_q       <= 1'b0;
         warn_sh_q      <= 1'b0;
         crc_rx_q       <= '0;
         timer_q        <= '0;
         period_q       <= '0;
         frame_valid_q  <= 1'b0;
         pos_out_q      <= '0;
         err_bit_q      <= 1'b0;
         warn_bit_q     <= 1'b0;
         crc_ok_q       <= 1'b0;
         proto_err_q    <= 1'b0;
         frame_cnt_q    <= '0;
         frame_period_q <= '0;
      end else begin
         ma_sync_q      <= SYNC_STAGES'({ma_sync_q, ma_in});
         slo_sync_q     <= SYNC_STAGES'({slo_sync_q, slo_in});
         ma_prev_q      <= ma_s;
         state_q        <= state_d;
         scnt_q         <= scnt_d;
         n_q            <= n_d;
         bit_q          <= bit_d;
         pos_sh_q       <= pos_sh_d;
         err_sh_q       <= err_sh_d;
         warn_sh_q      <= warn_sh_d;
         crc_rx_q       <= crc_rx_d;
         timer_q        <= timer_d;
         period_q       <= period_d;
         frame_valid_q  <= frame_valid_d;
         pos_out_q      <= pos_out_d;
         err_bit_q      <= err_bit_d;
         warn_bit_q     <= warn_bit_d;
         crc_ok_q       <= crc_ok_d;
         proto_err_q    <= proto_err_d;
         frame_cnt_q    <= frame_cnt_d;
         frame_period_q <= frame_period_d;
      end
   end

   assign ma_out       = ma_in;
   assign slo_out      = slo_in;
   assign frame_valid  = frame_valid_q;
   assign pos_out      = pos_out_q;
   assign err_bit      = err_bit_q;
   assign warn_bit     = warn_bit_q;
   assign crc_ok       = crc_ok_q;
   assign proto_err    = proto_err_q;
   assign frame_cnt    = frame_cnt_q;
   assign frame_period = frame_period_q;

endmodule

// File: tb/tb_biss_rx_frame_v3.sv
// Scoreboard bench for biss_rx_frame_v3: random BiSS-C frames against a
// bit-list reference model with polynomial long-division CRC.
module tb_biss_rx_frame_v3;

   localparam int POS_W_MAX   = 32;
   localparam int SYNC_STAGES = 2;
   localparam int SYNC_EDGES  = 2;
   localparam int BIT_TO      = 50;
   localparam int ACK_TO      = 2000;
   localparam int PERIOD_W    = 32;

   logic                 clk = 1'b0;
   logic                 rst, motion_en, ma_in, slo_in;
   logic [7:0]           cfg_pos_width;
   logic                 ma_out, slo_out, frame_valid, err_bit, warn_bit, crc_ok, proto_err;
   logic [POS_W_MAX-1:0] pos_out;
   logic [15:0]          frame_cnt;
   logic [PERIOD_W-1:0]  frame_period;

   biss_rx_frame_v3 #(
      .POS_W_MAX(POS_W_MAX), .SYNC_STAGES(SYNC_STAGES), .SYNC_EDGES(SYNC_EDGES),
      .BIT_TO(BIT_TO), .ACK_TO(ACK_TO), .PERIOD_W(PERIOD_W)
   ) dut (
      .clk(clk), .rst(rst), .motion_en(motion_en), .cfg_pos_width(cfg_pos_width),
      .ma_in(ma_in), .slo_in(slo_in), .ma_out(ma_out), .slo_out(slo_out),
      .frame_valid(frame_valid), .pos_out(pos_out), .err_bit(err_bit),
      .warn_bit(warn_bit), .crc_ok(crc_ok), .proto_err(proto_err),
      .frame_cnt(frame_cnt), .frame_period(frame_period)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pos;
      logic        err, warn, ok;
      logic [15:0] cnt;
      logic [31:0] period;
      bit          period_known;
   } exp_t;

   exp_t        exp_q[$];
   int          proto_q[$];
   exp_t        mon_e;
   int          checks = 0, failures = 0;
   int          last_fall_cyc = 0;
   int          half = 20;
   logic [15:0] exp_cnt = '0;
   bit          prev_start_valid = 0;
   int          prev_start = 0;
   logic [31:0] last_pos = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clamp_w(input int cfg);
      return (cfg < 8 || cfg > POS_W_MAX) ? POS_W_MAX : cfg;
   endfunction

   // Remainder of msg(x)*x^6 divided by x^6+x+1.
   function automatic logic [5:0] crc6_ref(input bit msg[$]);
      bit         m[$];
      logic [6:0] gen = 7'b1000011;
      logic [5:0] r = '0;
      m = msg;
      repeat (6) m.push_back(1'b0);
      for (int i = 0; i < msg.size(); i++)
         if (m[i]) for (int j = 0; j < 7; j++) m[i+j] = m[i+j] ^ gen[6-j];
      for (int j = 0; j < 6; j++) r = {r[4:0], m[msg.size()+j]};
      return r;
   endfunction

   // Scoreboard monitor, sampling on the falling clock edge.
   always @(negedge clk) begin
      if (!rst && motion_en) begin
         if (frame_valid) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_frame_valid at cycle %0d", cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("pos_out", 64'(pos_out), 64'(mon_e.pos));
               check("err_bit", 64'(err_bit), 64'(mon_e.err));
               check("warn_bit", 64'(warn_bit), 64'(mon_e.warn));
               check("crc_ok", 64'(crc_ok), 64'(mon_e.ok));
               check("frame_cnt", 64'(frame_cnt), 64'(mon_e.cnt));
               check("latency", 64'(cyc), 64'(last_fall_cyc + SYNC_STAGES + 2));
               if (mon_e.period_known) check("frame_period", 64'(frame_period), 64'(mon_e.period));
            end
         end
         if (proto_err) begin
            if (proto_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_proto_err at cycle %0d", cyc);
            end else begin
               check("proto_err_time", 64'(cyc), 64'(proto_q.pop_front()));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
      check({tag, "_pos_out"}, 64'(pos_out), 64'd0);
      check({tag, "_err_bit"}, 64'(err_bit), 64'd0);
      check({tag, "_warn_bit"}, 64'(warn_bit), 64'd0);
      check({tag, "_crc_ok"}, 64'(crc_ok), 64'd0);
      check({tag, "_proto_err"}, 64'(proto_err), 64'd0);
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
      check({tag, "_frame_period"}, 64'(frame_period), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1; ma_in = 1'b1; slo_in = 1'b1;
      tick(3);
      check_all_zero("reset");
      exp_q.delete(); proto_q.delete();
      exp_cnt = '0; prev_start_valid = 0; last_pos = '0;
      rst = 1'b0;
      tick(5);
   endtask

   // One MA period: rise (SLO updated), then the sampling fall.
   task automatic send_bit(input logic b);
      ma_in = 1'b1; slo_in = b;
      tick(half);
      ma_in = 1'b0;
      last_fall_cyc = cyc;
      #1;
      check("ma_passthru", 64'(ma_out), 64'(ma_in));
      check("slo_passthru", 64'(slo_out), 64'(slo_in));
      tick(half);
   endtask

   task automatic send_frame(input logic [7:0] cfg, input logic [31:0] pos, input logic e,
                             input logic w, input int flip, input int n_ack,
                             input int stall_at, input int drop_at, input int target);
      int          n;
      bit          msg[$];
      logic [5:0]  tx;
      logic [63:0] mask;
      exp_t        it;
      bit          good;
      n    = clamp_w(int'(cfg));
      good = (stall_at < 0 && drop_at < 0);
      cfg_pos_width = cfg;
      for (int i = n - 1; i >= 0; i--) msg.push_back(pos[i]);
      msg.push_back(e);
      msg.push_back(w);
      tx = ~crc6_ref(msg);
      if (flip >= 0) tx[5-flip] = ~tx[5-flip];
      if (target > 0)
         while (cyc < target - ((SYNC_EDGES + n_ack) * 2 * half + half)) tick(1);
      repeat (SYNC_EDGES) send_bit(1'b1);
      cfg_pos_width = 8'($urandom);
      repeat (n_ack) send_bit(1'b0);
      send_bit(1'b1);
      if (good) begin
         mask            = (64'd1 << n) - 64'd1;
         it.pos          = pos & mask[31:0];
         it.err          = e;
         it.warn         = w;
         it.ok           = (flip < 0);
         it.cnt          = exp_cnt + 16'd1;
         it.period_known = prev_start_valid;
         it.period       = 32'(last_fall_cyc - prev_start);
         exp_cnt         = exp_cnt + 16'd1;
         last_pos        = it.pos;
         exp_q.push_back(it);
      end
      prev_start = last_fall_cyc;
      prev_start_valid = 1;
      send_bit(1'b0);
      for (int i = 0; i < n + 8; i++) begin
         if (i == stall_at) begin
            ma_in = 1'b1; slo_in = 1'b1;
            proto_q.push_back(cyc + SYNC_STAGES + BIT_TO + 2);
            tick(BIT_TO + 15);
            check("pos_hold", 64'(pos_out), 64'(last_pos));
            return;
         end
         if (i == drop_at) begin
            motion_en = 1'b0;
            tick(1);
            check_all_zero("drop");
            ma_in = 1'b1; slo_in = 1'b1;
            tick(10);
            motion_en = 1'b1;
            exp_cnt = '0; prev_start_valid = 0; last_pos = '0;
            tick(10);
            return;
         end
         send_bit((i < n + 2) ? logic'(msg[i]) : tx[5-(i-n-2)]);
      end
      ma_in = 1'b1; slo_in = 1'b1;
      tick(20 + $urandom_range(0, 30));
   endtask

   task automatic ack_timeout();
      repeat (SYNC_EDGES) send_bit(1'b1);
      send_bit(1'b0);
      ma_in = 1'b1;
      proto_q.push_back(cyc + SYNC_STAGES + ACK_TO + 2);
      tick(ACK_TO + 20);
      slo_in = 1'b1;
      tick(20);
   endtask

   task automatic sync_abort();
      send_bit(1'b1);
      send_bit(1'b0);
      ma_in = 1'b1; slo_in = 1'b1;
      tick(20);
   endtask

   initial begin
      rst = 1'b1; motion_en = 1'b1; ma_in = 1'b1; slo_in = 1'b1; cfg_pos_width = 8'd18;
      do_reset();

      send_frame(8'd18, 32'h0002A5A5, 1'b1, 1'b1, -1, 1, -1, -1, 0);
      send_frame(8'd18, 32'h0002A5A5, 1'b1, 1'b1, 5, 1, -1, -1, 0);

      do_reset();
      send_frame(8'd26, 32'h03FFFFFF, 1'b0, 1'b0, -1, 1, -1, -1, 0);
      send_frame(8'd26, 32'h03FFFFFF, 1'b0, 1'b1, -1, 1, -1, -1, prev_start + 6250);
      check("period_6250", 64'(frame_period), 64'd6250);
      check("cnt_two", 64'(frame_cnt), 64'd2);

      send_frame(8'd26, 32'h01234567, 1'b1, 1'b0, -1, 2, 12, -1, 0);
      send_frame(8'd20, 32'h000ABCDE, 1'b0, 1'b1, -1, 1, -1, -1, 0);

      ack_timeout();
      send_frame(8'd40, 32'hDEADBEEF, 1'b1, 1'b1, -1, 1, -1, -1, 0);

      send_frame(8'd18, 32'h00012345, 1'b0, 1'b0, -1, 1, -1, 10, 0);
      send_frame(8'd18, 32'h00012345, 1'b0, 1'b0, -1, 1, -1, -1, 0);
      check("cnt_after_drop", 64'(frame_cnt), 64'd1);

      for (int it = 0; it < 16; it++) begin
         int kind, n_sel, cfg_r;
         half  = $urandom_range(8, 22);
         kind  = $urandom_range(0, 9);
         cfg_r = $urandom_range(0, 45);
         n_sel = clamp_w(cfg_r);
         case (kind)
            6: send_frame(8'(cfg_r), $urandom, 1'($urandom), 1'($urandom), -1,
                          $urandom_range(1, 3), $urandom_range(0, n_sel + 7), -1, 0);
            7: sync_abort();
            8: ack_timeout();
            default: send_frame(8'(cfg_r), $urandom, 1'($urandom), 1'($urandom),
                                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1,
                                $urandom_range(1, 3), -1, -1, 0);
         endcase
      end

      tick(50);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("proto_queue_drained", 64'(proto_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1500000;
      checks++; failures++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
